// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave note player feeding the audio DAC serializer.
// One note per handshake; plays for N beats, then an optional silent gap.
module note_tone_gen #(
    parameter int DIV_W       = 22,
    parameter int BEAT_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [DIV_W-1:0] note_div,
    input  logic [3:0]       note_beats,
    input  logic [2:0]       volume,
    input  logic             mute,
    output logic [15:0]      audio_left,
    output logic [15:0]      audio_right,
    output logic             playing
);
    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] div_cnt;
    logic             phase;
    logic [BW-1:0]    beat_cnt;
    logic [3:0]       beats_left;
    logic [GW-1:0]    gap_cnt;
    logic [15:0]      sample;
    logic [15:0]      sample_n;
    logic [15:0]      amp;
    logic             accept;
    logic             div_wrap;
    logic             beat_wrap;
    logic             gap_done;

    assign note_ready  = (state == IDLE);
    assign playing     = (state == PLAY);
    assign audio_left  = sample;
    assign audio_right = sample;
    assign amp         = {1'b0, volume, 12'h000};

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        div_wrap  = (div_cnt == div_lat - DIV_W'(1));
        beat_wrap = (beat_cnt == BEAT_LAST);
        gap_done  = (gap_cnt == GAP_LAST);
        sample_n  = 16'h0000;
        unique case (state)
            IDLE: begin
                if (note_valid) begin
                    accept  = 1'b1;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (beat_wrap && beats_left == 4'd1)
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                // a rest (div 0) plays silence for its full duration
                if (!mute && div_lat != '0)
                    sample_n = phase ? amp : (~amp + 16'd1);
            end
            GAP: begin
                if (gap_done)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_lat    <= '0;
            div_cnt    <= '0;
            phase      <= 1'b0;
            beat_cnt   <= '0;
            beats_left <= '0;
            gap_cnt    <= '0;
            sample     <= '0;
        end else begin
            state  <= state_n;
            sample <= sample_n;
            if (accept) begin
                div_lat    <= note_div;
                beats_left <= (note_beats == 4'd0) ? 4'd1 : note_beats;
                div_cnt    <= '0;
                beat_cnt   <= '0;
                phase      <= 1'b1;
                gap_cnt    <= '0;
            end else if (state == PLAY) begin
                if (div_lat != '0) begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                if (beat_wrap) begin
                    beat_cnt   <= '0;
                    beats_left <= beats_left - 4'd1;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_note_tone_gen.sv
// Directed testbench for note_tone_gen (BEAT_CYCLES=16, GAP_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_note_tone_gen;
    localparam int DIV_W = 22;

    logic             clk;
    logic             rst;
    logic             note_valid;
    logic             note_ready;
    logic [DIV_W-1:0] note_div;
    logic [3:0]       note_beats;
    logic [2:0]       volume;
    logic             mute;
    logic [15:0]      audio_left;
    logic [15:0]      audio_right;
    logic             playing;

    int checks = 0;
    int errors = 0;

    note_tone_gen #(
        .DIV_W(DIV_W),
        .BEAT_CYCLES(16),
        .GAP_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_div(note_div),
        .note_beats(note_beats),
        .volume(volume),
        .mute(mute),
        .audio_left(audio_left),
        .audio_right(audio_right),
        .playing(playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake in cycle T; returns at the falling edge of cycle T+1.
    task automatic send_note(input logic [DIV_W-1:0] d, input logic [3:0] b);
        int n = 0;
        while (note_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (note_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_note_ready: got %b, want 1", note_ready);
        end
        note_div   = d;
        note_beats = b;
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        note_valid = 1'b1;
        note_div   = 22'd4;
        note_beats = 4'd1;
        volume     = 3'd3;
        mute       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (note_ready !== 1'b1 || playing !== 1'b0 ||
                audio_left !== 16'h0 || audio_right !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: rdy=%b play=%b l=%h r=%h, want 1 0 0 0",
                         i, note_ready, playing, audio_left, audio_right);
            end
        end
        rst        = 1'b0;
        note_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (note_ready !== 1'b1 || playing !== 1'b0 ||
                audio_left !== 16'h0 || audio_right !== 16'h0) begin
                errors++;
                $display("FAIL reset_after[%0d]: rdy=%b play=%b l=%h r=%h, want 1 0 0 0",
                         i, note_ready, playing, audio_left, audio_right);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] ea;
        logic        ep;
        logic        er;
        volume = 3'd3;
        mute   = 1'b0;
        send_note(22'd4, 4'd2);
        for (int k = 1; k <= 37; k++) begin
            ep = (k <= 32);
            er = (k >= 37);
            if (k >= 2 && k <= 33)
                ea = (((k - 2) / 4) % 2 == 0) ? 16'h3000 : 16'hD000;
            else
                ea = 16'h0000;
            checks++;
            if (playing !== ep) begin
                errors++;
                $display("FAIL basic_playing T+%0d: got %b, want %b", k, playing, ep);
            end
            checks++;
            if (audio_left !== ea || audio_right !== ea) begin
                errors++;
                $display("FAIL basic_audio T+%0d: got %h/%h, want %h",
                         k, audio_left, audio_right, ea);
            end
            checks++;
            if (note_ready !== er) begin
                errors++;
                $display("FAIL basic_ready T+%0d: got %b, want %b", k, note_ready, er);
            end
            if (k < 37) @(negedge clk);
        end
    endtask

    task automatic test_rest_and_fast();
        logic [15:0] ea;
        volume = 3'd3;
        send_note(22'd0, 4'd1);
        for (int k = 1; k <= 21; k++) begin
            checks++;
            if (playing !== (k <= 16) || audio_left !== 16'h0 ||
                note_ready !== (k >= 21)) begin
                errors++;
                $display("FAIL rest T+%0d: play=%b l=%h rdy=%b, want %b 0000 %b",
                         k, playing, audio_left, note_ready, (k <= 16), (k >= 21));
            end
            if (k < 21) @(negedge clk);
        end
        volume = 3'd7;
        send_note(22'd1, 4'd1);
        for (int k = 1; k <= 21; k++) begin
            if (k >= 2 && k <= 17)
                ea = (k % 2 == 0) ? 16'h7000 : 16'h9000;
            else
                ea = 16'h0000;
            checks++;
            if (audio_left !== ea || audio_right !== ea ||
                playing !== (k <= 16) || note_ready !== (k >= 21)) begin
                errors++;
                $display("FAIL fast T+%0d: l=%h r=%h play=%b rdy=%b, want %h %b %b",
                         k, audio_left, audio_right, playing, note_ready,
                         ea, (k <= 16), (k >= 21));
            end
            if (k < 21) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea;
        volume = 3'd3;
        send_note(22'd2, 4'd0);
        note_valid = 1'b1;
        note_div   = 22'd5;
        note_beats = 4'd3;
        for (int k = 1; k <= 21; k++) begin
            if (k >= 2 && k <= 17)
                ea = (((k - 2) / 2) % 2 == 0) ? 16'h3000 : 16'hD000;
            else
                ea = 16'h0000;
            checks++;
            if (audio_left !== ea || playing !== (k <= 16) ||
                note_ready !== (k >= 21)) begin
                errors++;
                $display("FAIL b2b_first T+%0d: l=%h play=%b rdy=%b, want %h %b %b",
                         k, audio_left, playing, note_ready, ea, (k <= 16), (k >= 21));
            end
            if (k < 21) @(negedge clk);
        end
        @(negedge clk);
        note_valid = 1'b0;
        for (int j = 1; j <= 53; j++) begin
            if (j >= 2 && j <= 49)
                ea = (((j - 2) / 5) % 2 == 0) ? 16'h3000 : 16'hD000;
            else
                ea = 16'h0000;
            checks++;
            if (audio_left !== ea || playing !== (j <= 48) ||
                note_ready !== (j >= 53)) begin
                errors++;
                $display("FAIL b2b_second T+%0d: l=%h play=%b rdy=%b, want %h %b %b",
                         j, audio_left, playing, note_ready, ea, (j <= 48), (j >= 53));
            end
            if (j < 53) @(negedge clk);
        end
    endtask

    task automatic test_mute_volume();
        logic [15:0] ea;
        logic [15:0] amp;
        volume = 3'd3;
        mute   = 1'b0;
        send_note(22'd4, 4'd2);
        for (int k = 1; k <= 37; k++) begin
            amp = (k >= 13) ? 16'h1000 : 16'h3000;
            if (k >= 2 && k <= 33 && !(k >= 4 && k <= 8))
                ea = (((k - 2) / 4) % 2 == 0) ? amp : (~amp + 16'd1);
            else
                ea = 16'h0000;
            checks++;
            if (audio_left !== ea || audio_right !== ea ||
                playing !== (k <= 32) || note_ready !== (k >= 37)) begin
                errors++;
                $display("FAIL mute_vol T+%0d: l=%h r=%h play=%b rdy=%b, want %h %b %b",
                         k, audio_left, audio_right, playing, note_ready,
                         ea, (k <= 32), (k >= 37));
            end
            if (k == 3) mute = 1'b1;
            if (k == 8) mute = 1'b0;
            if (k == 12) volume = 3'd1;
            if (k < 37) @(negedge clk);
        end
        volume = 3'd3;
    endtask

    task automatic test_abort();
        logic [15:0] ea;
        volume = 3'd3;
        send_note(22'd4, 4'd2);
        for (int k = 1; k <= 10; k++) begin
            if (k >= 2)
                ea = (((k - 2) / 4) % 2 == 0) ? 16'h3000 : 16'hD000;
            else
                ea = 16'h0000;
            checks++;
            if (audio_left !== ea || playing !== 1'b1) begin
                errors++;
                $display("FAIL abort_pre T+%0d: l=%h play=%b, want %h 1",
                         k, audio_left, playing, ea);
            end
            if (k < 10) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (audio_left !== 16'h0 || audio_right !== 16'h0 ||
            playing !== 1'b0 || note_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: l=%h r=%h play=%b rdy=%b, want 0 0 0 1",
                     audio_left, audio_right, playing, note_ready);
        end
        rst = 1'b0;
        send_note(22'd3, 4'd1);
        for (int j = 1; j <= 21; j++) begin
            if (j >= 2 && j <= 17)
                ea = (((j - 2) / 3) % 2 == 0) ? 16'h3000 : 16'hD000;
            else
                ea = 16'h0000;
            checks++;
            if (audio_left !== ea || playing !== (j <= 16) ||
                note_ready !== (j >= 21)) begin
                errors++;
                $display("FAIL abort_next T+%0d: l=%h play=%b rdy=%b, want %h %b %b",
                         j, audio_left, playing, note_ready, ea, (j <= 16), (j >= 21));
            end
            if (j < 21) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rest_and_fast();
        test_back_to_back();
        test_mute_volume();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Upstream sample source for the audio DAC serializer.
- Accepts one note at a time over a valid/ready handshake.
- Plays each note as a square wave for a programmable number of beats, then inserts a short silent gap.
- Drives identical 16-bit signed samples onto audio_left/audio_right, which the serializer shifts out MSB first.

Parameters:
- DIV_W, 22, width of the half-period divider (clk cycles).
- BEAT_CYCLES, 25000000, clk cycles per beat.
- GAP_CYCLES, 1000000, clk cycles of silence after each note; 0 = no gap.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous active-high reset.
- note_valid  in  1  note request.
- note_ready  out  1  high only in IDLE.
- note_div  in  DIV_W  half-period in clk cycles; 0 = rest.
- note_beats  in  4  duration in beats; 0 treated as 1.
- volume  in  3  amplitude level, sampled live every cycle.
- mute  in  1  forces samples to 0; timing unaffected.
- audio_left  out  16  signed sample to serializer.
- audio_right  out  16  equal to audio_left.
- playing  out  1  high while in PLAY.

Behaviour:
- Reset is synchronous and active-high; one clock domain (clk). Reset has priority over all other inputs.
- On reset: state=IDLE, note_ready=1, playing=0, audio_left/right=16'h0000, and phase, divider, beat, beats-left and gap counters all cleared.
- States and transitions:
  - IDLE: note_ready=1. A handshake (note_valid&note_ready) in cycle T latches note_div and note_beats (0 becomes 1). The block enters PLAY at T+1 with div_cnt=0, beat_cnt=0, phase=1.
  - PLAY: note_ready=0; note_valid is ignored.
    - div_cnt increments each cycle. When div_cnt==div_lat-1, div_cnt wraps to 0 and phase toggles.
    - div_lat=1 toggles phase every cycle. div_lat=0 (rest) holds phase, and the output is 0.
    - beat_cnt increments each cycle. At BEAT_CYCLES-1 it wraps and beats_left decrements.
    - A wrap with beats_left==1 exits PLAY, to GAP, or to IDLE if GAP_CYCLES==0.
    - PLAY lasts exactly beats*BEAT_CYCLES cycles.
  - GAP: outputs 0. Counts GAP_CYCLES cycles, then enters IDLE.
- Sample arithmetic:
  - amp = {1'b0, volume, 12'h000}, so volume 3 gives 16'h3000 and volume 7 gives 16'h7000.
  - phase=1 gives +amp; phase=0 gives two's-complement -amp (volume 3 gives 16'hD000).
  - The sample is 0 when mute=1, div_lat=0, volume=0, or state!=PLAY.
- Samples are registered: one cycle latency from state/phase/mute/volume to output.
  - First nonzero sample appears at T+2.
  - Output returns to 0 the cycle after PLAY ends.
- Derived timing: note_ready reasserts at T+1+beats*BEAT_CYCLES+GAP_CYCLES.
- A reset arriving mid-PLAY or mid-GAP aborts the note. Next cycle: IDLE state, zero outputs, note_ready=1.
- Counters never overflow: widths are sized from BEAT_CYCLES, GAP_CYCLES and DIV_W.

Test Plan (BEAT_CYCLES=16, GAP_CYCLES=4):
1. Reset, hold rst 3 cycles with note_valid=1 -> during and after reset: note_ready=1, playing=0, audio=0; no note accepted while rst=1.
2. Handshake at T with div=4, beats=2, volume=3 -> playing high T+1..T+32; audio 16'h3000 for T+2..T+5, 16'hD000 for T+6..T+9, alternating through T+33; audio 0 T+34..T+37; note_ready=1 at T+37.
3. div=0, beats=1 -> playing high 16 cycles, audio stays 0; note_ready at T+21. Then div=1, volume=7 -> audio alternates 16'h7000/16'h9000 every cycle.
4. beats=0, div=2 -> PLAY lasts 16 cycles. note_valid held high with new values during PLAY -> ignored; next note is accepted only at the IDLE cycle.
5. Mid-note: mute=1 for 5 cycles, then volume changes 3->1 -> audio 0 one cycle after mute rises; resumes with correct phase; ±16'h1000 one cycle after the volume change; note end time unchanged.
6. Assert rst at PLAY cycle 10 -> next cycle audio=0, playing=0, note_ready=1. A new note is then accepted normally with phase=1 first.
